mac_serial_param: RTL and testbench

Parametrised next-generation multiply-accumulate engine behind a byte-serial streaming interface. It accepts DATA_W-bit operands as little-endian byte streams and multiplies them in signed or unsigned mode. The product is cleared into, or accumulated onto, an ACC_W-bit accumulator, and the full accumulator is returned as a byte stream with valid/ready backpressure. It sits between the top-level pin adapter and the pins, and replaces the fixed 8x8 / 17-bit datapath.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_mul_acc.sv | 99 +++++++++
 rtl/mac_serial_param.sv | 133 +++++++++++++
 tb/tb_mac_serial_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the byte-serial multiply-accumulate engine.
package mac_pkg;

  localparam int MAC_BYTE_W = 8;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_MUL,
    S_ACC,
    S_DRAIN
  } state_t;

  function automatic int bytes_for(input int width);
    return (width + MAC_BYTE_W - 1) / MAC_BYTE_W;
  endfunction

endpackage

// File: rtl/mac_mul_acc.sv
// Product register, accumulator and sticky overflow for the serial MAC.
// MAC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module mac_mul_acc
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_signed,
  input  logic              i_clear,
  input  logic              i_mul_en,
  input  logic              i_acc_en,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_overflow
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    r_prod_p0;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] r_acc_p1;
  logic             r_ovf;
  logic             w_carry;
  logic             w_sovf;
  logic             w_ovf_now;

`ifdef MAC_SATURATE_EN
  function automatic logic [ACC_W-1:0] sat_fn(input logic sgn, input logic neg);
    if (!sgn)
      return {ACC_W{1'b1}};
    else if (neg)
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction
`endif

  // Operands widened to the product width; the low 2*DATA_W bits of the
  // product of extended patterns equal the true signed/unsigned product.
  always_comb begin
    if (i_signed) begin
      w_a_ext = {{DATA_W{i_a[DATA_W-1]}}, i_a};
      w_b_ext = {{DATA_W{i_b[DATA_W-1]}}, i_b};
    end else begin
      w_a_ext = {{DATA_W{1'b0}}, i_a};
      w_b_ext = {{DATA_W{1'b0}}, i_b};
    end
  end

  assign w_prod = w_a_ext * w_b_ext;

  // Stage p0: product register
  always_ff @(posedge clk) begin
    if (i_mul_en) r_prod_p0 <= w_prod;
  end

  always_comb begin
    if (i_signed) w_ext = ACC_W'($signed(r_prod_p0));
    else          w_ext = ACC_W'(r_prod_p0);
  end

  assign w_sum     = {1'b0, r_acc_p1} + {1'b0, w_ext};
  assign w_carry   = w_sum[ACC_W];
  assign w_sovf    = (r_acc_p1[ACC_W-1] == w_ext[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc_p1[ACC_W-1]);
  assign w_ovf_now = i_signed ? w_sovf : w_carry;

  // Stage p1: accumulator, cleared on reset so an abandoned op leaves no residue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_p1 <= '0;
      r_ovf    <= 1'b0;
    end else if (i_acc_en) begin
      if (i_clear) begin
        r_acc_p1 <= w_ext;
        r_ovf    <= 1'b0;
      end else begin
`ifdef MAC_SATURATE_EN
        r_acc_p1 <= w_ovf_now ? sat_fn(i_signed, r_acc_p1[ACC_W-1]) : w_sum[ACC_W-1:0];
`else
        r_acc_p1 <= w_sum[ACC_W-1:0];
`endif
        r_ovf    <= r_ovf | w_ovf_now;
      end
    end
  end

  assign o_acc      = r_acc_p1;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/mac_serial_param.sv
// Byte-serial MAC front end: operand deserialiser, control FSM and result drain.
// MAC_SATURATE_EN (in mac_mul_acc) selects saturating accumulation.
module mac_serial_param
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       clear_and_mult,
  input  logic       signed_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       overflow,
  output logic       busy
);

  localparam int NB    = bytes_for(DATA_W);
  localparam int NR    = bytes_for(ACC_W);
  localparam int CNT_W = 4;
  localparam int PAD_W = NR * MAC_BYTE_W;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_op_clear;
  logic              r_op_signed;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [ACC_W-1:0]  w_acc;
  logic              w_ovf;
  logic [PAD_W-1:0]  w_acc_pad;
  logic [7:0]        w_byte;

  mac_mul_acc #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mul_acc (
    .clk       (clk),
    .rst       (rst),
    .i_a       (r_a),
    .i_b       (r_b),
    .i_signed  (r_op_signed),
    .i_clear   (r_op_clear),
    .i_mul_en  (r_state == S_MUL),
    .i_acc_en  (r_state == S_ACC),
    .o_acc     (w_acc),
    .o_overflow(w_ovf)
  );

  assign in_ready   = !rst && ((r_state == S_LOAD_A) || (r_state == S_LOAD_B));
  assign out_valid  = !rst && (r_state == S_DRAIN);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    if (r_op_signed) w_acc_pad = PAD_W'($signed(w_acc));
    else             w_acc_pad = PAD_W'(w_acc);
  end

  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NR; i++)
      if (r_cnt == CNT_W'(i)) w_byte = w_acc_pad[i*MAC_BYTE_W +: MAC_BYTE_W];
  end

  assign out_data = out_valid ? w_byte : 8'h00;
  assign out_last = out_valid && (r_cnt == CNT_W'(NR - 1));
  assign overflow = !rst && w_ovf;
  assign busy     = !rst && !((r_state == S_LOAD_A) && (r_cnt == '0));

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      for (int i = 0; i < NB; i++) begin
        if (r_cnt == CNT_W'(i)) begin
          if (r_state == S_LOAD_A) r_a[i*MAC_BYTE_W +: MAC_BYTE_W] <= in_data;
          else                     r_b[i*MAC_BYTE_W +: MAC_BYTE_W] <= in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD_A;
      r_cnt       <= '0;
      r_op_clear  <= 1'b0;
      r_op_signed <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD_A: if (w_in_xfer) begin
          if (r_cnt == '0) begin
            r_op_clear  <= clear_and_mult;
            r_op_signed <= signed_mode;
          end
          if (r_cnt == CNT_W'(NB - 1)) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_B;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LOAD_B: if (w_in_xfer) begin
          if (r_cnt == CNT_W'(NB - 1)) begin
            r_cnt   <= '0;
            r_state <= S_MUL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MUL: r_state <= S_ACC;
        S_ACC: r_state <= S_DRAIN;
        S_DRAIN: if (w_out_xfer) begin
          if (r_cnt == CNT_W'(NR - 1)) begin
            r_cnt   <= '0;
            r_state <= S_LOAD_A;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_serial_param.sv
// Bench for mac_serial_param: ACC_W=24 and ACC_W=16 instances fed the same byte stream.
module tb_mac_serial_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clear_and_mult = 1'b0;
  logic       signed_mode = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready_w  [2];
  logic       out_valid_w [2];
  logic [7:0] out_data_w  [2];
  logic       out_last_w  [2];
  logic       overflow_w  [2];
  logic       busy_w      [2];

  always #5 clk = ~clk;

  mac_serial_param #(.DATA_W(8), .ACC_W(24)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_data(in_data), .clear_and_mult(clear_and_mult), .signed_mode(signed_mode),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_last(out_last_w[0]), .overflow(overflow_w[0]), .busy(busy_w[0])
  );

  mac_serial_param #(.DATA_W(8), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_data(in_data), .clear_and_mult(clear_and_mult), .signed_mode(signed_mode),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_last(out_last_w[1]), .overflow(overflow_w[1]), .busy(busy_w[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // entries are {overflow, last, data}
  logic [9:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];
  longint     m_acc[2];
  bit         m_ovf[2];
  logic       pend[2];
  logic [8:0] pend_val[2];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the accumulator value per width.
  task automatic model_op(input logic [7:0] a, input logic [7:0] b, input logic clr, input logic sgn);
    for (int d = 0; d < 2; d++) begin
      int w;
      longint md, half, p, s, acc_s;
      bit ov;
      logic [9:0] e;
      w    = (d == 0) ? 24 : 16;
      md   = longint'(1) << w;
      half = md / 2;
      p    = sgn ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
      if (clr) begin
        m_acc[d] = ((p % md) + md) % md;
        m_ovf[d] = 1'b0;
      end else begin
        acc_s = (sgn && m_acc[d] >= half) ? m_acc[d] - md : m_acc[d];
        s     = acc_s + p;
        ov    = sgn ? (s >= half || s < -half) : (s >= md);
        if (ov) m_ovf[d] = 1'b1;
`ifdef MAC_SATURATE_EN
        if (ov) m_acc[d] = sgn ? ((s > 0) ? half - 1 : half) : md - 1;
        else    m_acc[d] = ((s % md) + md) % md;
`else
        m_acc[d] = ((s % md) + md) % md;
`endif
      end
      for (int i = 0; i < w / 8; i++) begin
        e = {m_ovf[d], (i == w / 8 - 1), 8'((m_acc[d] >> (8 * i)) & 255)};
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [9:0] e;
      bit have;
      if (rst) begin
        check($sformatf("reset_outputs dut%0d", d),
              {in_ready_w[d], out_valid_w[d], out_last_w[d], overflow_w[d], busy_w[d], out_data_w[d]}, 0);
        pend[d] = 1'b0;
      end else begin
        if (pend[d])
          check($sformatf("hold dut%0d", d), {out_valid_w[d], out_last_w[d], out_data_w[d]}, {1'b1, pend_val[d]});
        if (out_valid_w[d] && out_ready) begin
          have = 1'b0;
          e    = '0;
          if (d == 0) begin
            if (exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
            got_q0.push_back({overflow_w[d], out_last_w[d], out_data_w[d]});
          end else begin
            if (exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
            got_q1.push_back({overflow_w[d], out_last_w[d], out_data_w[d]});
          end
          if (!have) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte dut%0d: got 0x%02h, required no byte", d, out_data_w[d]);
          end else begin
            check($sformatf("stream dut%0d {ovf,last,data}", d),
                  {overflow_w[d], out_last_w[d], out_data_w[d]}, e);
          end
        end
        pend[d]     = out_valid_w[d] && !out_ready;
        pend_val[d] = {out_last_w[d], out_data_w[d]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr, input logic sgn);
    int guard = 0;
    while (!(in_ready_w[0] && in_ready_w[1]) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, required 1 within 100 cycles");
    end else begin
      in_valid       = 1'b1;
      in_data        = b;
      clear_and_mult = clr;
      signed_mode    = sgn;
      tick();
      in_valid       = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(in_ready_w[0] && in_ready_w[1] && !busy_w[0] && !busy_w[1]) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy, required idle within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                        input logic sgn, input bit bp);
    int guard = 0;
    got_q0.delete();
    got_q1.delete();
    send_byte(a, clr, sgn);
    check("busy after first byte", {busy_w[0], busy_w[1]}, 2'b11);
    // mode inputs flipped on the B byte must be ignored
    send_byte(b, ~clr, ~sgn);
    model_op(a, b, clr, sgn);
    if (bp) begin
      out_ready = 1'b0;
      while (!out_valid_w[0] && guard < 20) begin tick(); guard++; end
      check("drain starts", out_valid_w[0], 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("pulse1 bytes", got_q0.size(), 1);
      repeat (5) tick();
      check("no byte while stalled", got_q0.size(), 1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("pulse2 bytes", got_q0.size(), 2);
      tick();
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("pulse3 bytes", got_q0.size(), 3);
      out_ready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic chk_bytes(input string nm, input int d, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic ov);
    logic [7:0] bs[3];
    logic [9:0] g;
    int n, sz;
    bs = '{b0, b1, b2};
    n  = (d == 0) ? 3 : 2;
    sz = (d == 0) ? got_q0.size() : got_q1.size();
    check({nm, " count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++) begin
      g = (d == 0) ? got_q0[i] : got_q1[i];
      check($sformatf("%s byte%0d", nm, i), g[7:0], bs[i]);
      check($sformatf("%s last%0d", nm, i), g[8], (i == n - 1));
      check($sformatf("%s ovf%0d", nm, i), g[9], ov);
    end
  endtask

  initial begin
    m_acc = '{0, 0};
    m_ovf = '{0, 0};
    pend  = '{0, 0};
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("in_ready after reset", {in_ready_w[0], in_ready_w[1]}, 2'b11);
    check("busy idle", {busy_w[0], busy_w[1]}, 2'b00);

    run_op(8'd200, 8'd100, 1'b1, 1'b0, 1'b0);
    chk_bytes("uclear24", 0, 8'h20, 8'h4E, 8'h00, 1'b0);
    chk_bytes("uclear16", 1, 8'h20, 8'h4E, 8'h00, 1'b0);

    run_op(8'hFD, 8'h05, 1'b1, 1'b1, 1'b0);
    chk_bytes("sclear24", 0, 8'hF1, 8'hFF, 8'hFF, 1'b0);
    chk_bytes("sclear16", 1, 8'hF1, 8'hFF, 8'h00, 1'b0);

    run_op(8'd3, 8'd4, 1'b1, 1'b0, 1'b0);
    run_op(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
    chk_bytes("accum24", 0, 8'h2A, 8'h00, 8'h00, 1'b0);

    run_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
    chk_bytes("backpressure24", 0, 8'hA8, 8'h03, 8'h00, 1'b0);

    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    chk_bytes("uovf_clear16", 1, 8'h01, 8'hFE, 8'h00, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
`ifdef MAC_SATURATE_EN
    chk_bytes("uovf_add16", 1, 8'hFF, 8'hFF, 8'h00, 1'b1);
`else
    chk_bytes("uovf_add16", 1, 8'h02, 8'hFC, 8'h00, 1'b1);
`endif
    chk_bytes("uovf_add24", 0, 8'h02, 8'hFC, 8'h01, 1'b0);

    run_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
`ifdef MAC_SATURATE_EN
    chk_bytes("sovf_add16", 1, 8'hFF, 8'h7F, 8'h00, 1'b1);
`else
    chk_bytes("sovf_add16", 1, 8'h00, 8'h80, 8'h00, 1'b1);
`endif
    chk_bytes("sovf_add24", 0, 8'h00, 8'h80, 8'h00, 1'b0);

    run_op(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    chk_bytes("scarry_no_ovf16", 1, 8'h00, 8'h00, 8'h00, 1'b0);

    // abandon an op in LOAD_B; the accumulator must come back cleared
    send_byte(8'd7, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    m_acc = '{0, 0};
    m_ovf = '{0, 0};
    rst = 1'b0;
    #1;
    check("in_ready after mid-op reset", {in_ready_w[0], in_ready_w[1]}, 2'b11);
    tick();
    run_op(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    chk_bytes("post_reset24", 0, 8'h06, 8'h00, 8'h00, 1'b0);

    tick();
    check("expected queue24 drained", exp_q0.size(), 0);
    check("expected queue16 drained", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
